// File: rtl/ext_obi_mem_responder_pkg.sv
// Shared constants and types for the external OBI memory responder.
// Holds the external-slave address window defaults, the poison word
// returned for out-of-range reads, and the request/response structs
// used inside the responder and its response pipe.
package ext_obi_mem_responder_pkg;

  // External-slave address window used by the SoC top.
  localparam logic [31:0] EXT_SLAVE_START_ADDR = 32'hF000_0000;
  localparam logic [31:0] EXT_SLAVE_MEM_SIZE   = 32'h0000_2000;
  localparam logic [31:0] EXT_SLAVE_POISON     = 32'hBADC_AB1E;

  // Wide enough for the largest supported grant wait (7).
  localparam int unsigned GNT_CNT_W = 3;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } obi_rsp_t;

endpackage

// File: rtl/ext_obi_mem_responder_rsp_pipe.sv
// ext_obi_rsp_pipe: fixed-latency, in-order response delay line.
// LATENCY stages of {valid, data}; stage 0 loads at acceptance and the
// last stage drives the outputs, so a response appears LATENCY cycles
// after the accepting edge. Reset flushes every in-flight response.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   in_valid_i      a transaction is accepted this cycle
//   in_data_i       response data for that transaction
//   out_valid_o     response valid
//   out_data_o      response data (0 when out_valid_o=0)
module ext_obi_rsp_pipe
  import ext_obi_mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o
);

  obi_rsp_t [LATENCY-1:0] stage_d, stage_q;

  always_comb begin
    stage_d    = '0;
    // Data is zeroed on idle slots so rdata_o reads 0 whenever rvalid_o=0.
    stage_d[0] = {in_valid_i, (in_valid_i ? in_data_i : 32'h0)};
    for (int i = 1; i < int'(LATENCY); i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stage_q <= '0;
    else         stage_q <= stage_d;
  end

  assign out_valid_o = stage_q[LATENCY-1].valid;
  assign out_data_o  = stage_q[LATENCY-1].data;

endmodule

// File: rtl/ext_obi_mem_responder.sv
// ext_obi_mem_responder: OBI slave terminating an external-slave port.
// Word-addressed, byte-enabled memory with a configurable grant wait and
// a fixed in-order response latency. Out-of-range reads return POISON,
// out-of-range writes are dropped; every granted request gets a response.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   req_i, we_i, be_i,
//   addr_i, wdata_i            OBI request channel
//   gnt_o                      request accepted this cycle
//   rvalid_o, rdata_o          OBI response channel (rdata 0 for writes)
module ext_obi_mem_responder
  import ext_obi_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = EXT_SLAVE_START_ADDR,
  parameter logic [31:0] MEM_SIZE     = EXT_SLAVE_MEM_SIZE,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned GNT_WAIT     = 0,
  parameter logic [31:0] POISON       = EXT_SLAVE_POISON
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned WORDS = MEM_SIZE >> 2;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  obi_req_t               req_s;
  logic [GNT_CNT_W-1:0]   wait_cnt_d, wait_cnt_q;
  logic                   accept;
  logic [31:0]            offset;
  logic                   in_range;
  logic [IW-1:0]          word_idx;
  logic [31:0]            rd_word;
  logic [31:0]            rsp_data;
  logic [31:0]            mem [WORDS];

  assign req_s = {we_i, be_i, addr_i, wdata_i};

  // Grant wait. With GNT_WAIT=0 the counter never leaves 0, so the grant
  // collapses to gnt_o = req_i without a separate code path.
  assign gnt_o  = req_i && (wait_cnt_q == GNT_CNT_W'(GNT_WAIT));
  assign accept = req_i && gnt_o;

  always_comb begin
    wait_cnt_d = '0;
    // Counting only while a request is pending also clears the counter
    // when the master drops req_i before the grant.
    if (req_i && !gnt_o) wait_cnt_d = wait_cnt_q + GNT_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wait_cnt_q <= '0;
    else         wait_cnt_q <= wait_cnt_d;
  end

  // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge
  // offsets, so one compare covers both ends of the window.
  assign offset   = req_s.addr - BASE_ADDR;
  assign in_range = offset < MEM_SIZE;
  assign word_idx = offset[IW+1:2];

  // Combinational read at acceptance sees pre-write contents; the write
  // lands at the same edge, so the next cycle already reads it back.
  assign rd_word  = in_range ? mem[word_idx] : POISON;
  assign rsp_data = req_s.we ? 32'h0 : rd_word;

  // Storage is not reset; writes accepted before a reset must survive it.
  always_ff @(posedge clk_i) begin
    if (accept && req_s.we && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (req_s.be[k]) mem[word_idx][8*k +: 8] <= req_s.wdata[8*k +: 8];
      end
    end
  end

  ext_obi_rsp_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rsp_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (accept),
    .in_data_i   (rsp_data),
    .out_valid_o (rvalid_o),
    .out_data_o  (rdata_o)
  );

endmodule

// File: tb/tb_ext_obi_mem_responder.sv
// Directed bench for ext_obi_mem_responder. Three instances cover the
// parameter sets of interest: A (GNT_WAIT=0, READ_LATENCY=1),
// B (GNT_WAIT=2, READ_LATENCY=3), C (GNT_WAIT=0, READ_LATENCY=4).
// Inputs change 1 time unit after the rising edge, outputs are sampled
// on the falling edge.
module tb_ext_obi_mem_responder;

  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [31:0] bd [3];

  always #5 clk = ~clk;

  ext_obi_mem_responder #(.READ_LATENCY(1), .GNT_WAIT(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]));

  ext_obi_mem_responder #(.READ_LATENCY(3), .GNT_WAIT(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]));

  ext_obi_mem_responder #(.READ_LATENCY(4), .GNT_WAIT(0)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv(input int d, input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] wd);
    req[d]   = r;
    we[d]    = w;
    be[d]    = b;
    addr[d]  = a;
    wdata[d] = wd;
  endtask

  task automatic idle(input int d);
    drv(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Compares {gnt, rvalid, rdata} of instance d against the expectation.
  task automatic rsp(input int d, input string tag, input logic g, input logic v,
                     input logic [31:0] rd);
    logic [33:0] obs, exp;
    obs = {gnt[d], rvalid[d], rdata[d]};
    exp = {g, v, rd};
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed gnt/rvalid/rdata=%h expected %h", tag, obs, exp);
    end
  endtask

  // Three back-to-back transfers on instance B, each held until granted.
  // Grants land at k=2,5,8 (two wait cycles each), responses at k=5,8,11.
  task automatic b_burst(input logic w, input string tag);
    logic eg, ev;
    logic [31:0] ed;
    int   slot;
    for (int k = 0; k < 13; k++) begin
      slot = (k < 9) ? k / 3 : 0;
      drv(1, k < 9, w, 4'hF, BASE + 32'(4 * slot), bd[slot]);
      mid();
      eg = (k == 2) || (k == 5) || (k == 8);
      ev = (k == 5) || (k == 8) || (k == 11);
      ed = (ev && !w) ? bd[(k - 5) / 3] : 32'h0;
      rsp(1, $sformatf("%s_k%0d", tag, k), eg, ev, ed);
      step();
    end
  endtask

  initial begin
    bd[0] = 32'h1111_0001;
    bd[1] = 32'h2222_0002;
    bd[2] = 32'h3333_0003;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) idle(d);

    // Reset and idle.
    mid();
    for (int d = 0; d < 3; d++) rsp(d, $sformatf("in_reset_%0d", d), 1'b0, 1'b0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mid();
      for (int d = 0; d < 3; d++) rsp(d, $sformatf("idle_%0d_c%0d", d, c), 1'b0, 1'b0, 32'h0);
      step();
    end

    // A: full-word write then read at zero gap.
    drv(0, 1, 1, 4'hF, 32'hF000_0010, 32'hDEAD_BEEF);
    mid(); rsp(0, "wr_full", 1, 0, 32'h0); step();
    drv(0, 1, 0, 4'hF, 32'hF000_0010, 32'h0);
    mid(); rsp(0, "rd_full_wrsp", 1, 1, 32'h0); step();
    idle(0);
    mid(); rsp(0, "rd_full_data", 0, 1, 32'hDEAD_BEEF); step();

    // A: byte enables.
    drv(0, 1, 1, 4'hF, 32'hF000_0020, 32'h1122_3344);
    mid(); rsp(0, "be_wr1", 1, 0, 32'h0); step();
    drv(0, 1, 1, 4'b0101, 32'hF000_0020, 32'hAABB_CCDD);
    mid(); rsp(0, "be_wr2", 1, 1, 32'h0); step();
    drv(0, 1, 0, 4'h0, 32'hF000_0020, 32'h0);
    mid(); rsp(0, "be_rd", 1, 1, 32'h0); step();
    idle(0);
    mid(); rsp(0, "be_data", 0, 1, 32'h11BB_33DD); step();
    mid(); rsp(0, "be_quiet", 0, 0, 32'h0); step();

    // A: out-of-range accesses; word 0 must stay intact.
    drv(0, 1, 1, 4'hF, 32'hF000_0000, 32'h0BAD_F00D);
    mid(); rsp(0, "oor_w0", 1, 0, 32'h0); step();
    drv(0, 1, 0, 4'hF, 32'hF000_2000, 32'h0);
    mid(); rsp(0, "oor_rd_hi", 1, 1, 32'h0); step();
    drv(0, 1, 0, 4'hF, 32'hEFFF_FFFC, 32'h0);
    mid(); rsp(0, "oor_rd_lo", 1, 1, 32'hBADC_AB1E); step();
    drv(0, 1, 1, 4'hF, 32'hF000_2000, 32'h1);
    mid(); rsp(0, "oor_wr", 1, 1, 32'hBADC_AB1E); step();
    drv(0, 1, 0, 4'hF, 32'hF000_0000, 32'h0);
    mid(); rsp(0, "oor_wr_rsp", 1, 1, 32'h0); step();
    idle(0);
    mid(); rsp(0, "w0_intact", 0, 1, 32'h0BAD_F00D); step();
    mid(); rsp(0, "oor_quiet", 0, 0, 32'h0); step();

    // B: grant wait and latency, writes to preload then reads in order.
    b_burst(1'b1, "b_wr");
    b_burst(1'b0, "b_rd");

    // C: reset while a read is in flight.
    drv(2, 1, 1, 4'hF, 32'hF000_0040, 32'hCAFE_F00D);
    mid(); rsp(2, "rst_wr", 1, 0, 32'h0); step();
    drv(2, 1, 0, 4'hF, 32'hF000_0040, 32'h0);
    mid(); rsp(2, "rst_rd_gnt", 1, 0, 32'h0); step();
    idle(2);
    mid(); rsp(2, "rst_g1", 0, 0, 32'h0); step();
    rst_n = 1'b0;
    mid(); rsp(2, "rst_active", 0, 0, 32'h0); step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      mid(); rsp(2, $sformatf("rst_drop_c%0d", c), 0, 0, 32'h0); step();
    end
    drv(2, 1, 0, 4'hF, 32'hF000_0040, 32'h0);
    mid(); rsp(2, "post_rd_gnt", 1, 0, 32'h0); step();
    idle(2);
    for (int c = 0; c < 3; c++) begin
      mid(); rsp(2, $sformatf("post_wait_c%0d", c), 0, 0, 32'h0); step();
    end
    mid(); rsp(2, "post_rd_data", 0, 1, 32'hCAFE_F00D); step();
    mid(); rsp(2, "post_quiet", 0, 0, 32'h0); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ext_obi_mem_responder.md
Name: ext_obi_mem_responder

Overview:
- OBI slave that terminates one external-slave port of the X-HEEP bus. It is the responder behind the external memory window that the MCU initiates into.
- Word-addressed, byte-enabled memory with a configurable grant wait and a fixed, in-order read latency.
- Instantiated in the SoC top on an external slave port selected by the external-slave address rules.
- Out-of-range accesses complete with a defined poison value, so the bus never hangs.

Parameters:
- BASE_ADDR, 32'hF000_0000, byte address of word 0; equals the external-slave start address of the window.
- MEM_SIZE, 32'h2000, window size in bytes; a power of two, at least 4.
- READ_LATENCY, 1, cycles from the grant cycle to rvalid_o; legal range 1..4.
- GNT_WAIT, 0, wait cycles inserted before gnt_o; legal range 0..7.
- POISON, 32'hBADC_AB1E, rdata_o value for an out-of-range read.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  OBI request valid
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables
- addr_i  in  32  byte address
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid; one per granted request
- rdata_o  out  32  read data; 0 for writes

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, wait counter=0, response pipe flushed. Memory contents are not reset.
- Grant, GNT_WAIT=0: gnt_o = req_i, combinational. One transaction per cycle.
- Grant, GNT_WAIT=N>0:
  - The counter increments while req_i=1 and gnt_o=0.
  - gnt_o=1 in the cycle the counter equals N. The counter clears on grant.
  - Back-to-back requests each pay N wait cycles.
  - The counter clears if req_i drops before grant. Dropping is a master protocol violation; the block ignores it silently.
- Acceptance: a transfer happens in the cycle with req_i & gnt_o. Attributes are sampled only in that cycle.
- Decode:
  - in_range = (addr_i - BASE_ADDR) < MEM_SIZE, unsigned 32-bit arithmetic. The wrap below BASE_ADDR yields out of range.
  - Word index = (addr_i - BASE_ADDR)[log2(MEM_SIZE)-1:2]. addr_i[1:0] is ignored.
- Write, in range: each byte lane k with be_i[k]=1 is written at the acceptance edge. Other lanes are unchanged.
- Write, out of range: discarded.
- Write response: rvalid_o with rdata_o=0.
- Read:
  - Memory is sampled at acceptance, with pre-write contents if the same cycle writes (the same cycle cannot both read and write).
  - Read data is independent of be_i; all 4 bytes are returned.
  - Out-of-range reads return POISON.
- Response timing: a transaction granted in cycle t gives rvalid_o=1 in cycle t+READ_LATENCY, registered.
  - Responses come in order. Up to READ_LATENCY responses are in flight.
  - There is no back-pressure; OBI requires the master to accept rvalid.
  - rdata_o returns to 0 when rvalid_o=0.
- Ordering: a read granted after a write to the same word returns the written data, including at zero gap.
- Reset mid-operation: in-flight responses are dropped, and no rvalid_o follows. Memory is preserved. Any write accepted before reset assertion stands.

Decomposition:
- Shared package: add EXT_SLAVE_POISON and the MEM_SIZE/BASE defaults next to the existing external-slave address constants. The SoC instantiates with those package values.
- Sub-module ext_obi_rsp_pipe:
  - READ_LATENCY-deep shift register of {valid, data}.
  - Ports clk_i, rst_ni, in_valid_i, in_data_i, out_valid_o, out_data_o.
  - Stage 0 is loaded at acceptance.
- Storage is a behavioural array of MEM_SIZE/4 words with per-byte write enables; a memory macro can replace it later.

Test Plan:
- Reset then idle, checked each cycle for 10 cycles -> gnt_o=0, rvalid_o=0, rdata_o=0.
- Full-word write then read, GNT_WAIT=0, READ_LATENCY=1:
  - Write 32'hDEADBEEF at 0xF0000010, be=4'hF, then read 0xF0000010 in the next cycle.
  - -> gnt_o same cycle as each req. rvalid_o at t+1 (rdata 0) and t+2 (rdata 32'hDEADBEEF).
- Byte enables:
  - Write 32'h11223344 at 0xF0000020, be=4'hF, then write 32'hAABBCCDD with be=4'b0101, then read.
  - -> rdata 32'h11BB33DD.
- Out of range:
  - Read 0xF0002000, read 0xEFFFFFFC, and write 0xF0002000 with data 1.
  - -> reads return 32'hBADCAB1E, write returns rdata 0. Word 0 reads unchanged.
- Wait and latency, GNT_WAIT=2, READ_LATENCY=3:
  - Three back-to-back reads held until granted.
  - -> each gnt_o 2 cycles after req_i rises. Each rvalid_o exactly 3 cycles after its grant, in order.
- Reset mid-flight, READ_LATENCY=4:
  - Grant a read, assert rst_ni=0 two cycles later for one cycle.
  - -> no rvalid_o follows. A subsequent read returns the pre-reset memory contents.
